// File: rtl/led7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM state encoding,
// the all-off segment pattern and a counter-width helper.
package led7_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led7_scan_ctrl_dec.sv
// BCD to 7-segment decoder, active-high segments a..g on seg[0]..seg[6].
// Inputs a..d are the BCD bits with a as the MSB. Codes above 9 give a dark digit.
module led7_scan_ctrl_dec
    import led7_scan_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [6:0] seg
);

    // Glyph lookup on the 4-bit code.
    always_comb begin
        seg = SEG_BLANK;
        case ({a, b, c, d})
            4'd0:    seg = 7'b011_1111;
            4'd1:    seg = 7'b000_0110;
            4'd2:    seg = 7'b101_1011;
            4'd3:    seg = 7'b100_1111;
            4'd4:    seg = 7'b110_0110;
            4'd5:    seg = 7'b110_1101;
            4'd6:    seg = 7'b111_1101;
            4'd7:    seg = 7'b000_0111;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b110_1111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display.
// One shared decoder, anti-ghost blanking between digits and a shadow buffer
// so new values only reach the pins on frame boundaries.
module led7_scan_ctrl
    import led7_scan_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzb,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W = clog2_min1(DIGITS);
    localparam int CNT_W = clog2_min1(PRESCALE);
    localparam int BLK_W = clog2_min1(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    scan_state_t          state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BLK_W-1:0]     blk_reg, blk_next;
    logic                 step_digit, frame_end, apply;

    logic [4*DIGITS-1:0]  active_bcd_reg, shadow_bcd_reg, cur_bcd;
    logic [DIGITS-1:0]    active_dp_reg, shadow_dp_reg, cur_dp;
    logic                 active_lzb_reg, shadow_lzb_reg, cur_lzb;
    logic                 busy_reg, frame_done_reg;

    logic [DIGITS-1:0]    an_reg, an_next;
    logic [6:0]           seg_reg, seg_next, dec_seg;
    logic                 dp_reg, dp_next, drive_next;

    logic [3:0]           nib [DIGITS];
    logic [DIGITS-1:0]    lz_blank;
    logic [3:0]           sel_nib;

    // Next scan position: slot timing, digit advance and frame-boundary detection.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        blk_next   = blk_reg;
        step_digit = 1'b0;
        frame_end  = 1'b0;
        apply      = 1'b0;
        if (!en) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
            blk_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Starting from a dark display is also a frame boundary,
                    // so pending data is shown from the very first frame.
                    state_next = DRIVE;
                    idx_next   = '0;
                    cnt_next   = '0;
                    blk_next   = '0;
                    apply      = busy_reg;
                end
                DRIVE: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
                        if (BLANK_CYC == 0) begin
                            step_digit = 1'b1;
                        end else begin
                            state_next = BLANK;
                            blk_next   = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                BLANK: begin
                    if (blk_reg == BLK_LAST) begin
                        blk_next   = '0;
                        state_next = DRIVE;
                        step_digit = 1'b1;
                    end else begin
                        blk_next = blk_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                    blk_next   = '0;
                end
            endcase
            if (step_digit) begin
                if (idx_reg == IDX_LAST) begin
                    idx_next  = '0;
                    frame_end = 1'b1;
                    apply     = busy_reg;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
        end
    end

    // Data the next displayed digit comes from: the shadow when it is being applied now.
    assign cur_bcd = apply ? shadow_bcd_reg : active_bcd_reg;
    assign cur_dp  = apply ? shadow_dp_reg  : active_dp_reg;
    assign cur_lzb = apply ? shadow_lzb_reg : active_lzb_reg;

    // Per-digit nibble split and leading-zero blanking flags.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = cur_bcd[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = cur_lzb & ~|cur_bcd[4*DIGITS-1:4*gi];
            end
        end
    endgenerate

    assign sel_nib = nib[idx_next];

    led7_scan_ctrl_dec u_dec (
        .a   (sel_nib[3]),
        .b   (sel_nib[2]),
        .c   (sel_nib[1]),
        .d   (sel_nib[0]),
        .seg (dec_seg)
    );

    assign drive_next = (state_next == DRIVE);
    assign an_next    = drive_next ? (DIGITS'(1) << idx_next) : '0;
    assign seg_next   = (drive_next && !lz_blank[idx_next]) ? dec_seg : SEG_BLANK;
    assign dp_next    = drive_next & cur_dp[idx_next];

    // Scan FSM with registered pin outputs and the active/shadow double buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            blk_reg        <= '0;
            active_bcd_reg <= '0;
            active_dp_reg  <= '0;
            active_lzb_reg <= 1'b0;
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
            shadow_lzb_reg <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            an_reg         <= '0;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            blk_reg        <= blk_next;
            frame_done_reg <= frame_end;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            if (apply) begin
                active_bcd_reg <= shadow_bcd_reg;
                active_dp_reg  <= shadow_dp_reg;
                active_lzb_reg <= shadow_lzb_reg;
            end
            // A load in the same cycle as an apply refills the shadow and keeps busy set.
            if (load) begin
                shadow_bcd_reg <= bcd_in;
                shadow_dp_reg  <= dp_in;
                shadow_lzb_reg <= lzb;
                busy_reg       <= 1'b1;
            end else if (apply) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Self-checking bench for led7_scan_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a frame-time model.
module tb_led7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int PRESCALE  = 4;
    localparam int BLANK_CYC = 1;
    localparam int SLOT      = PRESCALE + BLANK_CYC;
    localparam int FRAME     = DIGITS * SLOT;

    logic                clk;
    logic                rst;
    logic                en;
    logic                load;
    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic                lzb;
    logic                busy;
    logic                frame_done;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;

    led7_scan_ctrl #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lzb        (lzb),
        .busy       (busy),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks = 0;
    int fail_checks  = 0;
    int fd_seen      = 0;

    // Reference model: position within the running frame plus the two data buffers.
    bit                  m_run;
    int                  m_t;
    logic [4*DIGITS-1:0] m_act_bcd, m_sh_bcd;
    logic [DIGITS-1:0]   m_act_dp, m_sh_dp;
    bit                  m_act_lzb, m_sh_lzb, m_busy, m_fd;

    function automatic logic [6:0] glyph(input int n);
        string s;
        logic [6:0] m;
        case (n)
            0: s = "abcdef";
            1: s = "bc";
            2: s = "abdeg";
            3: s = "abcdg";
            4: s = "bcfg";
            5: s = "acdfg";
            6: s = "acdefg";
            7: s = "abc";
            8: s = "abcdefg";
            9: s = "abcdfg";
            default: s = "";
        endcase
        m = '0;
        for (int k = 0; k < s.len(); k++) m[s[k] - "a"] = 1'b1;
        return m;
    endfunction

    function automatic logic [6:0] exp_seg_of(input int digit);
        logic [4*DIGITS-1:0] upper;
        int n;
        upper = m_act_bcd >> (4 * digit);
        n = int'(upper[3:0]);
        if (n > 9) return 7'd0;
        if (m_act_lzb && digit > 0 && upper == 0) return 7'd0;
        return glyph(n);
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_busy = 0; m_fd = 0;
        m_act_bcd = '0; m_sh_bcd = '0; m_act_dp = '0; m_sh_dp = '0;
        m_act_lzb = 0; m_sh_lzb = 0;
    endtask

    task automatic model_step();
        bit apply;
        if (rst) return;
        apply = 0;
        m_fd  = 0;
        if (!en) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0; apply = m_busy;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0; m_fd = 1; apply = m_busy;
            end
        end
        if (apply) begin
            m_act_bcd = m_sh_bcd; m_act_dp = m_sh_dp; m_act_lzb = m_sh_lzb; m_busy = 0;
        end
        if (load) begin
            m_sh_bcd = bcd_in; m_sh_dp = dp_in; m_sh_lzb = lzb; m_busy = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) else begin
            fail_checks++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all();
        logic [DIGITS-1:0] e_an;
        logic [6:0]        e_seg;
        logic              e_dp;
        int                slot;
        e_an = '0; e_seg = '0; e_dp = 1'b0;
        if (m_run && (m_t % SLOT) < PRESCALE) begin
            slot  = m_t / SLOT;
            e_an  = DIGITS'(1) << slot;
            e_seg = exp_seg_of(slot);
            e_dp  = m_act_dp[slot];
        end
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("busy", 32'(busy), 32'(m_busy));
        check("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_seen++;
        check_all();
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d, input logic z);
        bcd_in = v; dp_in = d; lzb = z; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; lzb = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;

        // 1: reset in the middle of a drive slot, then restart
        en = 1'b1;
        repeat (6) tick();
        async_reset();
        en = 1'b1;
        tick();
        check("release_an", 32'(an), 32'h1);
        repeat (3) tick();

        // 2: 1234 over three frames, frame_done every FRAME cycles
        en = 1'b0;
        tick();
        do_load(16'h1234, 4'b0000, 1'b0);
        en = 1'b1;
        fd_seen = 0;
        repeat (60) tick();
        check("frame_done_count", 32'(fd_seen), 32'd2);

        // 3: mid-frame load waits for the boundary
        repeat (7) tick();
        do_load(16'h5678, 4'b0000, 1'b0);
        check("busy_after_load", 32'(busy), 32'h1);
        repeat (45) tick();

        // 4: leading-zero blanking on and off
        do_load(16'h0070, 4'b0000, 1'b1);
        repeat (2 * FRAME) tick();
        do_load(16'h0070, 4'b0000, 1'b0);
        repeat (2 * FRAME) tick();

        // 5: invalid nibble with decimal point still lit
        do_load(16'h12C4, 4'b0010, 1'b0);
        repeat (2 * FRAME) tick();

        // 6: drop enable during a blank gap, then restart with a full slot
        guard = 0;
        while (!(m_run && (m_t % SLOT) >= PRESCALE) && guard < 100) begin
            tick();
            guard++;
        end
        check("blank_reached", 32'(guard < 100), 32'h1);
        en = 1'b0;
        tick();
        check("dark_after_en_drop", 32'(an), 32'h0);
        tick();
        en = 1'b1;
        for (int k = 0; k < PRESCALE; k++) begin
            tick();
            check("restart_slot_an", 32'(an), 32'h1);
        end
        tick();
        check("restart_gap_an", 32'(an), 32'h0);

        // Randomized traffic: loads, enable drops, occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end
            en = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < DIGITS; i++) begin
                bcd_in[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            dp_in = DIGITS'($urandom);
            lzb   = 1'($urandom);
            load  = ($urandom_range(0, 7) == 0);
            tick();
            load = 1'b0;
        end

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule
